// File: rtl/video_timing_pkg.sv
// Shared video timing constants and coordinate type for the game display path.
package video_timing_pkg;

  typedef logic [8:0] coord_t;

  localparam int unsigned COORD_LIMIT = 511;

  localparam int unsigned DEF_H_DISPLAY = 256;
  localparam int unsigned DEF_H_BACK    = 23;
  localparam int unsigned DEF_H_FRONT   = 7;
  localparam int unsigned DEF_H_SYNC    = 23;
  localparam int unsigned DEF_V_DISPLAY = 240;
  localparam int unsigned DEF_V_TOP     = 5;
  localparam int unsigned DEF_V_BOTTOM  = 14;
  localparam int unsigned DEF_V_SYNC    = 3;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_H_MAX        = DEF_H_DISPLAY + DEF_H_BACK + DEF_H_FRONT + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;
  localparam int unsigned DEF_V_MAX        = DEF_V_DISPLAY + DEF_V_TOP + DEF_V_BOTTOM + DEF_V_SYNC - 1;

endpackage

// File: rtl/hvsync_generator_if.sv
// Beam coordinate / sync bundle driven by hvsync_generator, read by renderers.
interface hvsync_generator_if;
  import video_timing_pkg::*;

  coord_t hpos;
  coord_t vpos;
  logic   hsync;
  logic   vsync;
  logic   display_on;

  modport master (output hpos, vpos, hsync, vsync, display_on);
  modport slave  (input  hpos, vpos, hsync, vsync, display_on);
endinterface

// File: rtl/video_axis_counter.sv
// One timing axis: wrapping position counter, registered sync window flag,
// and a terminal-count flag that chains to the next axis.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned MAX             = DEF_H_MAX,
  parameter int unsigned SYNC_START      = DEF_H_SYNC_START,
  parameter int unsigned SYNC_END        = DEF_H_SYNC_END,
  parameter bit          SYNC_ACTIVE_LOW = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  output coord_t o_pos,
  output logic   o_sync,
  output logic   o_tc
);

  coord_t r_pos;
  logic   r_sync;
  logic   w_tc;
  logic   w_in_win;

  assign w_tc     = (r_pos == coord_t'(MAX));
  assign w_in_win = (r_pos >= coord_t'(SYNC_START)) && (r_pos <= coord_t'(SYNC_END));

  // Sync samples the window every clock, independent of the enable, so the
  // vertical pulse tracks vpos with a single clock of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_sync <= SYNC_ACTIVE_LOW;
    end else begin
      r_sync <= w_in_win ^ SYNC_ACTIVE_LOW;
      if (i_en) begin
        r_pos <= w_tc ? '0 : r_pos + coord_t'(1);
      end
    end
  end

  assign o_pos  = r_pos;
  assign o_sync = r_sync;
  assign o_tc   = w_tc;

endmodule

// File: rtl/hvsync_generator.sv
// Free-running video timing generator (hpos/vpos, hsync/vsync, display_on).
// Define HVSYNC_ACTIVE_LOW_SYNC_EN for active-low sync pulses that idle high.
module hvsync_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_TOP     = DEF_V_TOP,
  parameter int unsigned V_BOTTOM  = DEF_V_BOTTOM,
  parameter int unsigned V_SYNC    = DEF_V_SYNC
) (
  input  logic               clk,
  input  logic               reset,
  hvsync_generator_if.master vid
);

  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int unsigned V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

`ifdef HVSYNC_ACTIVE_LOW_SYNC_EN
  localparam bit SYNC_ACTIVE_LOW = 1'b1;
`else
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
`endif

  if ((H_MAX > COORD_LIMIT) || (V_MAX > COORD_LIMIT)) begin : g_range_check
    $error("hvsync_generator: H_MAX/V_MAX exceed 9-bit coordinate range");
  end

  coord_t w_hpos;
  coord_t w_vpos;
  logic   w_hsync;
  logic   w_vsync;
  logic   w_h_tc;
  logic   w_unused_v_tc;

  video_axis_counter #(
    .MAX             (H_MAX),
    .SYNC_START      (H_SYNC_START),
    .SYNC_END        (H_SYNC_END),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (1'b1),
    .o_pos  (w_hpos),
    .o_sync (w_hsync),
    .o_tc   (w_h_tc)
  );

  video_axis_counter #(
    .MAX             (V_MAX),
    .SYNC_START      (V_SYNC_START),
    .SYNC_END        (V_SYNC_END),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_h_tc),
    .o_pos  (w_vpos),
    .o_sync (w_vsync),
    .o_tc   (w_unused_v_tc)
  );

  assign vid.hpos       = w_hpos;
  assign vid.vpos       = w_vpos;
  assign vid.hsync      = w_hsync;
  assign vid.vsync      = w_vsync;
  assign vid.display_on = (w_hpos < coord_t'(H_DISPLAY)) && (w_vpos < coord_t'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// Self-checking bench for hvsync_generator: per-cycle scoreboard plus checkpoint table.
module tb_hvsync_generator;

  localparam int unsigned H_TOT = 309;
  localparam int unsigned V_TOT = 262;
  localparam int unsigned HD    = 256;
  localparam int unsigned VD    = 240;
  localparam int unsigned HS0   = 263;
  localparam int unsigned HS1   = 285;
  localparam int unsigned VS0   = 254;
  localparam int unsigned VS1   = 256;
  localparam int unsigned FRAME = H_TOT * V_TOT;

`ifdef HVSYNC_ACTIVE_LOW_SYNC_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic reset;

  hvsync_generator_if vid();

  hvsync_generator dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sbq[$];
  vec_t        tab[$];
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned tab_k;
  int unsigned hs_cnt, vs_cnt, de_cnt;
  logic        hs_prev, vs_prev;

  function automatic exp_t model(int unsigned t);
    exp_t        e;
    int unsigned h, v, hp, vp;
    h    = t % H_TOT;
    v    = (t / H_TOT) % V_TOT;
    e.h  = 9'(h);
    e.v  = 9'(v);
    e.de = (h < HD) && (v < VD);
    if (t == 0) begin
      e.hs = POL;
      e.vs = POL;
    end else begin
      hp   = (t - 1) % H_TOT;
      vp   = ((t - 1) / H_TOT) % V_TOT;
      e.hs = ((hp >= HS0) && (hp <= HS1)) ^ POL;
      e.vs = ((vp >= VS0) && (vp <= VS1)) ^ POL;
    end
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.h  = vid.hpos;
    s.v  = vid.vpos;
    s.hs = vid.hsync;
    s.vs = vid.vsync;
    s.de = vid.display_on;
    return s;
  endfunction

  function automatic exp_t mk(int unsigned h, int unsigned v, logic hs, logic vs, logic de);
    exp_t e;
    e.h  = 9'(h);
    e.v  = 9'(v);
    e.hs = hs ^ POL;
    e.vs = vs ^ POL;
    e.de = de;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b de=%b, want h=%0d v=%0d hs=%b vs=%b de=%b",
               name, act.h, act.v, act.hs, act.vs, act.de, exp.h, exp.v, exp.hs, exp.vs, exp.de);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Advance to cycle t after release (t=0 is right after release) and score it.
  task automatic step(input int unsigned t);
    if (t != 0) @(posedge clk);
    sbq.push_back(model(t));
    #1;
    compare("cycle", sample(), sbq.pop_front());
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run(input int unsigned n, input bit stats);
    exp_t s;
    hs_cnt  = 0;
    vs_cnt  = 0;
    de_cnt  = 0;
    hs_prev = 1'b0;
    vs_prev = 1'b0;
    tab_k   = 0;
    for (int unsigned t = 0; t <= n; t++) begin
      step(t);
      if (stats) begin
        s = sample();
        if (t > 0 && s.h == 9'd0) begin
          check_int("hsync_width", hs_cnt, HS1 - HS0 + 1);
          hs_cnt = 0;
        end
        if (s.hs ^ POL) begin
          hs_cnt++;
          if (!hs_prev) check_int("hsync_first_hpos", 32'(s.h), 264);
        end
        if (s.vs ^ POL) begin
          vs_cnt++;
          if (!vs_prev) begin
            check_int("vsync_first_hpos", 32'(s.h), 1);
            check_int("vsync_first_vpos", 32'(s.v), VS0);
          end
        end
        if (t < FRAME && s.de) de_cnt++;
        hs_prev = s.hs ^ POL;
        vs_prev = s.vs ^ POL;
        if (tab_k < tab.size() && tab[tab_k].cyc == t) begin
          compare($sformatf("table[%0d]", tab_k), s, tab[tab_k].exp);
          tab_k++;
        end
      end
    end
    if (stats) begin
      check_int("vsync_width", vs_cnt, 927);
      check_int("display_count", de_cnt, 61440);
      check_int("table_applied", tab_k, tab.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Checkpoints in cycles after reset release (sync bits are active levels).
    tab.push_back('{0,             mk(0,   0,   0, 0, 1)});
    tab.push_back('{1,             mk(1,   0,   0, 0, 1)});
    tab.push_back('{255,           mk(255, 0,   0, 0, 1)});
    tab.push_back('{256,           mk(256, 0,   0, 0, 0)});
    tab.push_back('{263,           mk(263, 0,   0, 0, 0)});
    tab.push_back('{264,           mk(264, 0,   1, 0, 0)});
    tab.push_back('{286,           mk(286, 0,   1, 0, 0)});
    tab.push_back('{287,           mk(287, 0,   0, 0, 0)});
    tab.push_back('{308,           mk(308, 0,   0, 0, 0)});
    tab.push_back('{309,           mk(0,   1,   0, 0, 1)});
    tab.push_back('{239*309 + 255, mk(255, 239, 0, 0, 1)});
    tab.push_back('{240*309,       mk(0,   240, 0, 0, 0)});
    tab.push_back('{254*309,       mk(0,   254, 0, 0, 0)});
    tab.push_back('{254*309 + 1,   mk(1,   254, 0, 1, 0)});
    tab.push_back('{257*309,       mk(0,   257, 0, 1, 0)});
    tab.push_back('{257*309 + 1,   mk(1,   257, 0, 0, 0)});
    tab.push_back('{FRAME - 1,     mk(308, 261, 0, 0, 0)});
    tab.push_back('{FRAME,         mk(0,   0,   0, 0, 1)});

    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    compare("reset_state", sample(), mk(0, 0, 0, 0, 1));
    @(posedge clk);
    #1 compare("reset_held", sample(), mk(0, 0, 0, 0, 1));
    release_reset();

    // Run to (150,10), then pull reset between clock edges.
    run(10*309 + 150, 1'b0);
    #2 reset = 1'b0;
    #1 compare("async_reset", sample(), mk(0, 0, 0, 0, 1));
    @(posedge clk);
    #1 compare("async_reset_hold", sample(), mk(0, 0, 0, 0, 1));
    release_reset();

    run(FRAME, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
